// File: rtl/vending_mach_gen.sv
// Coin vending controller: accumulates credit, vends at PRICE, and returns excess
// or cancelled credit as a train of COIN_A-valued change pulses.
module vending_mach_gen #(
    parameter int CW         = 8,
    parameter int PRICE      = 15,
    parameter int COIN_A     = 5,
    parameter int COIN_B     = 10,
    parameter int MAX_CREDIT = 30
) (
    input  logic          clock,
    input  logic          rst,
    input  logic [1:0]    din,
    input  logic          cancel,
    output logic          dispense,
    output logic          change_out,
    output logic          coin_reject,
    output logic [CW-1:0] credit,
    output logic          busy
);

    generate
        if ((PRICE % COIN_A) != 0 || (COIN_B % COIN_A) != 0 || (MAX_CREDIT % COIN_A) != 0 ||
            PRICE > MAX_CREDIT || MAX_CREDIT >= (2 ** CW)) begin : g_bad_params
            $fatal(1, "vending_mach_gen: illegal parameter combination");
        end
    endgenerate

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_VEND,
        S_REFUND
    } state_t;

    // One extra bit so credit+coin can be compared against MAX_CREDIT without wrapping.
    localparam logic [CW:0] PRICE_W = (CW+1)'(PRICE);
    localparam logic [CW:0] MAX_W   = (CW+1)'(MAX_CREDIT);
    localparam logic [CW:0] COINA_W = (CW+1)'(COIN_A);
    localparam logic [CW:0] COINB_W = (CW+1)'(COIN_B);
    localparam logic [CW-1:0] UNIT  = CW'(COIN_A);

    state_t        state_q, state_d;
    logic [CW-1:0] credit_q, credit_d;
    logic          dispense_q, change_q, reject_q, busy_q;
    logic          reject_d;
    logic          coin_vld;
    logic [CW:0]   coin_val;
    logic [CW:0]   sum;

    assign coin_vld = din[1];
    assign coin_val = din[0] ? COINB_W : COINA_W;
    assign sum      = {1'b0, credit_q} + coin_val;

    always_comb begin
        state_d  = state_q;
        credit_d = credit_q;
        reject_d = 1'b0;
        case (state_q)
            S_IDLE, S_COLLECT: begin
                if (cancel && state_q == S_COLLECT) begin
                    // Cancel wins over a coin on the same edge.
                    state_d  = S_REFUND;
                    reject_d = coin_vld;
                end else if (coin_vld) begin
                    if (sum > MAX_W) begin
                        reject_d = 1'b1;
                    end else if (sum >= PRICE_W) begin
                        credit_d = CW'(sum - PRICE_W);
                        state_d  = S_VEND;
                    end else begin
                        credit_d = CW'(sum);
                        state_d  = S_COLLECT;
                    end
                end
            end
            S_VEND: begin
                reject_d = coin_vld;
                state_d  = (credit_q != '0) ? S_REFUND : S_IDLE;
            end
            S_REFUND: begin
                reject_d = coin_vld;
                if (credit_q <= UNIT) begin
                    credit_d = '0;
                    state_d  = S_IDLE;
                end else begin
                    credit_d = credit_q - UNIT;
                end
            end
            default: begin
                state_d  = S_IDLE;
                credit_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q    <= S_IDLE;
            credit_q   <= '0;
            dispense_q <= 1'b0;
            change_q   <= 1'b0;
            reject_q   <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            dispense_q <= (state_d == S_VEND);
            change_q   <= (state_d == S_REFUND);
            reject_q   <= reject_d;
            busy_q     <= (state_d == S_VEND) || (state_d == S_REFUND);
        end
    end

    assign dispense    = dispense_q;
    assign change_out  = change_q;
    assign coin_reject = reject_q;
    assign credit      = credit_q;
    assign busy        = busy_q;

endmodule

// File: tb/tb_vending_mach_gen.sv
// Scoreboard bench: two instances (default and MAX_CREDIT=15) share stimulus; a
// credit-arithmetic reference model predicts each cycle's outputs.
module tb_vending_mach_gen;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic       rst;
    logic [1:0] din;
    logic       cancel;

    logic       a_disp, a_chg, a_rej, a_busy;
    logic [7:0] a_cred;
    logic       b_disp, b_chg, b_rej, b_busy;
    logic [7:0] b_cred;

    vending_mach_gen #(.CW(8), .PRICE(15), .COIN_A(5), .COIN_B(10), .MAX_CREDIT(30)) dut_a (
        .clock(clock), .rst(rst), .din(din), .cancel(cancel),
        .dispense(a_disp), .change_out(a_chg), .coin_reject(a_rej), .credit(a_cred), .busy(a_busy)
    );

    vending_mach_gen #(.CW(8), .PRICE(15), .COIN_A(5), .COIN_B(10), .MAX_CREDIT(15)) dut_b (
        .clock(clock), .rst(rst), .din(din), .cancel(cancel),
        .dispense(b_disp), .change_out(b_chg), .coin_reject(b_rej), .credit(b_cred), .busy(b_busy)
    );

    typedef struct packed {
        logic       disp;
        logic       chg;
        logic       rej;
        logic       busy;
        logic [7:0] cred;
    } obs_t;

    obs_t expq_a[$];
    obs_t expq_b[$];
    int   checks   = 0;
    int   failures = 0;
    bit   stim_done = 0;

    // Model: credit held in value units; phase 0=accepting, 1=vending, 2=returning change.
    int m_cred[2];
    int m_phase[2];
    int m_max[2] = '{30, 15};

    function automatic obs_t model_step(int idx, logic r, logic [1:0] d, logic c);
        obs_t o;
        bit   coin = d[1];
        int   v    = d[0] ? 10 : 5;
        o = '0;
        if (r) begin
            m_cred[idx]  = 0;
            m_phase[idx] = 0;
            return o;
        end
        if (m_phase[idx] == 1) begin
            o.rej        = coin;
            m_phase[idx] = (m_cred[idx] > 0) ? 2 : 0;
        end else if (m_phase[idx] == 2) begin
            o.rej       = coin;
            m_cred[idx] = m_cred[idx] - 5;
            if (m_cred[idx] == 0) m_phase[idx] = 0;
        end else if (c && m_cred[idx] > 0) begin
            o.rej        = coin;
            m_phase[idx] = 2;
        end else if (coin) begin
            if (m_cred[idx] + v > m_max[idx]) begin
                o.rej = 1'b1;
            end else if (m_cred[idx] + v >= 15) begin
                m_cred[idx]  = m_cred[idx] + v - 15;
                m_phase[idx] = 1;
            end else begin
                m_cred[idx] = m_cred[idx] + v;
            end
        end
        o.disp = (m_phase[idx] == 1);
        o.chg  = (m_phase[idx] == 2);
        o.busy = (m_phase[idx] != 0);
        o.cred = 8'(m_cred[idx]);
        return o;
    endfunction

    task automatic drive(input logic r, input logic [1:0] d, input logic c);
        rst    = r;
        din    = d;
        cancel = c;
        expq_a.push_back(model_step(0, r, d, c));
        expq_b.push_back(model_step(1, r, d, c));
        @(posedge clock);
        #1;
    endtask

    task automatic compare(input string name, input obs_t act, input obs_t exp_o);
        checks++;
        if (act !== exp_o) begin
            failures++;
            $display("FAIL %s: got disp=%b chg=%b rej=%b busy=%b credit=%0d, expected disp=%b chg=%b rej=%b busy=%b credit=%0d",
                     name, act.disp, act.chg, act.rej, act.busy, act.cred,
                     exp_o.disp, exp_o.chg, exp_o.rej, exp_o.busy, exp_o.cred);
        end
    endtask

    // Monitor: every cycle the DUTs present a full output set, compared on the falling edge.
    initial begin
        obs_t act;
        forever begin
            @(negedge clock);
            if (expq_a.size() > 0) begin
                act = '{disp: a_disp, chg: a_chg, rej: a_rej, busy: a_busy, cred: a_cred};
                compare("inst_max30", act, expq_a.pop_front());
            end
            if (expq_b.size() > 0) begin
                act = '{disp: b_disp, chg: b_chg, rej: b_rej, busy: b_busy, cred: b_cred};
                compare("inst_max15", act, expq_b.pop_front());
            end
        end
    end

    localparam logic [1:0] NC = 2'b00;
    localparam logic [1:0] CA = 2'b10;
    localparam logic [1:0] CB = 2'b11;

    initial begin
        rst = 1'b1; din = NC; cancel = 1'b0;
        #1;
        drive(1, NC, 0);
        drive(1, NC, 0);
        // Three COIN_A: exact price, no change.
        drive(0, CA, 0); drive(0, CA, 0); drive(0, CA, 0); drive(0, NC, 0); drive(0, NC, 0);
        // COIN_B twice: vend (max30) or refuse (max15); coins offered while busy.
        drive(0, CB, 0); drive(0, CB, 0); drive(0, CB, 0); drive(0, CB, 0); drive(0, NC, 0);
        drive(0, CA, 0); drive(0, NC, 0); drive(0, NC, 0);
        drive(1, NC, 0);
        // COIN_A then cancel held: one pulse, extra cancels ignored.
        drive(0, CA, 0); drive(0, NC, 1); drive(0, NC, 1); drive(0, NC, 1); drive(0, NC, 0);
        // Coin on the cancel edge is refused.
        drive(0, CA, 0); drive(0, CB, 1); drive(0, NC, 0); drive(0, NC, 0);
        // No-coin code 01 changes nothing.
        drive(0, 2'b01, 0); drive(0, CA, 0); drive(0, 2'b01, 0); drive(0, NC, 0);
        drive(1, NC, 0);
        // Credit 10, cancel -> two pulses, reset during the second.
        drive(0, CB, 0); drive(0, NC, 1); drive(0, NC, 0); drive(1, NC, 0); drive(0, NC, 0); drive(0, NC, 0);
        // Randomised traffic with occasional reset.
        for (int i = 0; i < 3000; i++) begin
            logic [1:0] d;
            d = 2'($urandom_range(0, 3));
            drive(($urandom_range(0, 59) == 0), d, ($urandom_range(0, 5) == 0));
        end
        drive(0, NC, 0);
        stim_done = 1;
        repeat (4) @(posedge clock);
        checks++;
        if (expq_a.size() != 0 || expq_b.size() != 0) begin
            failures++;
            $display("FAIL drain: got pending=%0d/%0d, expected 0/0", expq_a.size(), expq_b.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
